// File: rtl/pump_pkg.sv
// Shared types and helpers for the pump scheduler.
//   pump_state_t  : per-channel schedule state
//   period_sel_t  : encodings of the 2-bit period choice
//   period_lookup : maps a period choice to seconds (code 3 aliases code 0)
package pump_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        WAIT   = 2'd2,
        MANUAL = 2'd3
    } pump_state_t;

    typedef enum logic [1:0] {
        PSEL_0   = 2'd0,
        PSEL_1   = 2'd1,
        PSEL_2   = 2'd2,
        PSEL_ALT = 2'd3
    } period_sel_t;

    function automatic logic [31:0] period_lookup(input logic [1:0]  psel,
                                                  input logic [31:0] p0,
                                                  input logic [31:0] p1,
                                                  input logic [31:0] p2);
        case (period_sel_t'(psel))
            PSEL_1:  return p1;
            PSEL_2:  return p2;
            default: return p0;
        endcase
    endfunction

endpackage

// File: rtl/pump_scheduler_if.sv
// Command/status bundle between the front-panel decoder and the scheduler.
//   sel, period_sel, pump_on, pump_off, manual_on : commands (master -> slave)
//   pump_out (active low), armed                  : status   (slave -> master)
interface pump_scheduler_if #(
    parameter int NUM_PUMPS = 3
);
    localparam int SEL_W = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1;

    logic [SEL_W-1:0]     sel;
    logic [1:0]           period_sel;
    logic                 pump_on;
    logic                 pump_off;
    logic                 manual_on;
    logic [NUM_PUMPS-1:0] pump_out;
    logic [NUM_PUMPS-1:0] armed;

    modport master (
        output sel, period_sel, pump_on, pump_off, manual_on,
        input  pump_out, armed
    );

    modport slave (
        input  sel, period_sel, pump_on, pump_off, manual_on,
        output pump_out, armed
    );
endinterface

// File: rtl/pump_channel.sv
// One pump channel: IDLE / PULSE / WAIT / MANUAL schedule engine.
//   arm    : latch period and (re)start a pulse
//   stop   : go idle (highest priority)
//   manual : one-shot from IDLE, early pulse from WAIT
//   period : period in seconds, captured on arm
//   pump_n : active-low pump drive (registered)
//   armed  : channel is under periodic schedule (registered)
module pump_channel
    import pump_pkg::*;
#(
    parameter int CLOCK_FREQ = 1_000_000,
    parameter int ON_SEC     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        stop,
    input  logic        manual,
    input  logic [31:0] period,
    output logic        pump_n,
    output logic        armed
);
    localparam int              PW        = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLOCK_FREQ - 1);
    localparam logic [31:0]     ON_S      = 32'(ON_SEC);

    pump_state_t   state, nxt;
    logic [PW-1:0] presc;
    logic [31:0]   secs, period_q, wait_s, tgt_s;
    logic          done, reenter;

    // Wait length never drops below one second, even for periods <= ON_SEC.
    assign wait_s = (period_q > ON_S) ? period_q - ON_S : 32'd1;
    assign tgt_s  = (state == WAIT) ? wait_s : ON_S;
    // Last cycle of the current state: tgt_s*CLOCK_FREQ cycles have elapsed.
    assign done   = (presc == PRESC_MAX) && (secs == tgt_s - 32'd1);

    // Commands outrank the natural end-of-state transition.
    always_comb begin
        nxt     = state;
        reenter = 1'b0;
        if (stop) begin
            nxt = IDLE;   reenter = 1'b1;
        end else if (arm) begin
            nxt = PULSE;  reenter = 1'b1;
        end else if (manual && state == IDLE) begin
            nxt = MANUAL; reenter = 1'b1;
        end else if (manual && state == WAIT) begin
            nxt = PULSE;  reenter = 1'b1;
        end else if (done) begin
            reenter = 1'b1;
            case (state)
                PULSE:   nxt = WAIT;
                WAIT:    nxt = PULSE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= '0;
            secs     <= '0;
            period_q <= '0;
            pump_n   <= 1'b1;
            armed    <= 1'b0;
        end else begin
            state <= nxt;
            // Counters restart on every state entry and stay cleared in IDLE.
            if (reenter || nxt == IDLE) begin
                presc <= '0;
                secs  <= '0;
            end else if (presc == PRESC_MAX) begin
                presc <= '0;
                secs  <= secs + 32'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (arm && !stop) period_q <= period;
            pump_n <= !(nxt == PULSE || nxt == MANUAL);
            armed  <= (nxt == PULSE || nxt == WAIT);
        end
    end
endmodule

// File: rtl/pump_scheduler.sv
// N-channel fragrance pump scheduler.
//   clk, rst_n : clock, async active-low reset
//   bus        : pump_scheduler_if slave (commands in, pump_out/armed out)
// Commands are registered once, decoded into per-channel arm/stop/manual
// strobes, and the channel outputs are concatenated onto the bus.
module pump_scheduler
    import pump_pkg::*;
#(
    parameter int NUM_PUMPS   = 3,
    parameter int CLOCK_FREQ  = 1_000_000,
    parameter int ON_SEC      = 5,
    parameter int PERIOD0_SEC = 1800,
    parameter int PERIOD1_SEC = 3600,
    parameter int PERIOD2_SEC = 7200
) (
    input logic              clk,
    input logic              rst_n,
    pump_scheduler_if.slave  bus
);
    localparam int SEL_W = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1;

    logic [SEL_W-1:0]     sel_q;
    logic [1:0]           psel_q;
    logic                 on_q, off_q, man_q;
    logic                 sel_ok;
    logic [31:0]          period_s;
    logic [NUM_PUMPS-1:0] pump_n_v, armed_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            psel_q <= '0;
            on_q   <= 1'b0;
            off_q  <= 1'b0;
            man_q  <= 1'b0;
        end else begin
            sel_q  <= bus.sel;
            psel_q <= bus.period_sel;
            on_q   <= bus.pump_on;
            off_q  <= bus.pump_off;
            man_q  <= bus.manual_on;
        end
    end

    // Out-of-range targets make pump_on/manual_on no-ops for every channel.
    assign sel_ok   = 32'(sel_q) < NUM_PUMPS;
    assign period_s = period_lookup(psel_q, 32'(PERIOD0_SEC),
                                    32'(PERIOD1_SEC), 32'(PERIOD2_SEC));

    for (genvar i = 0; i < NUM_PUMPS; i++) begin : g_ch
        logic hit;
        assign hit = sel_ok && (sel_q == SEL_W'(i));

        pump_channel #(
            .CLOCK_FREQ (CLOCK_FREQ),
            .ON_SEC     (ON_SEC)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .arm    (on_q && !off_q && hit),
            // Arming one channel retires whichever one held the schedule.
            .stop   (off_q || (on_q && sel_ok && !hit)),
            .manual (man_q && !on_q && !off_q && hit),
            .period (period_s),
            .pump_n (pump_n_v[i]),
            .armed  (armed_v[i])
        );
    end

    assign bus.pump_out = pump_n_v;
    assign bus.armed    = armed_v;
endmodule

// File: tb/tb_pump_scheduler.sv
module tb_pump_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   k, m;

    pump_scheduler_if #(.NUM_PUMPS(3)) bus ();

    pump_scheduler #(
        .NUM_PUMPS   (3),
        .CLOCK_FREQ  (10),
        .ON_SEC      (2),
        .PERIOD0_SEC (5),
        .PERIOD1_SEC (1),
        .PERIOD2_SEC (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    // Present one command for exactly one sampling edge.
    task automatic cmd(input logic on, input logic off, input logic man,
                       input logic [1:0] s, input logic [1:0] ps);
        bus.pump_on    = on;
        bus.pump_off   = off;
        bus.manual_on  = man;
        bus.sel        = s;
        bus.period_sel = ps;
        tick(1);
        bus.pump_on    = 1'b0;
        bus.pump_off   = 1'b0;
        bus.manual_on  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] po, input logic [2:0] ar);
        chk({tag, "_out"}, 32'(bus.pump_out), 32'(po));
        chk({tag, "_arm"}, 32'(bus.armed), 32'(ar));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pump_on = 1'b0; bus.pump_off = 1'b0; bus.manual_on = 1'b0;
        bus.sel = '0; bus.period_sel = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk_out("reset", 3'b111, 3'b000);

        // Arm ch1, period 5 s: 20-cycle pulse, 30-cycle wait.
        cmd(1, 0, 0, 2'd1, 2'd0); k = cyc;
        chk_out("arm_latency", 3'b111, 3'b000);
        tick(1);               chk_out("arm_start", 3'b101, 3'b010);
        tick_to(k + 20);       chk_out("arm_pulse_last", 3'b101, 3'b010);
        tick_to(k + 21);       chk_out("arm_wait_first", 3'b111, 3'b010);
        tick_to(k + 50);       chk_out("arm_wait_last", 3'b111, 3'b010);
        tick_to(k + 51);       chk_out("arm_repulse", 3'b101, 3'b010);

        // Arm ch0 with period 1 s: wait clamps to 1 s (10 cycles).
        cmd(1, 0, 0, 2'd0, 2'd1); k = cyc;
        tick(1);               chk_out("clamp_start", 3'b110, 3'b001);
        tick_to(k + 20);       chk_out("clamp_pulse_last", 3'b110, 3'b001);
        tick_to(k + 21);       chk_out("clamp_wait", 3'b111, 3'b001);
        tick_to(k + 30);       chk_out("clamp_wait_last", 3'b111, 3'b001);
        tick_to(k + 31);       chk_out("clamp_repulse", 3'b110, 3'b001);

        // Re-arm onto ch2 (period 5 s): ch0 drops out on the same edge.
        cmd(1, 0, 0, 2'd2, 2'd0); k = cyc;
        tick(1);               chk_out("rearm", 3'b011, 3'b100);
        // Manual one-shot on ch1, runs k+3..k+22.
        cmd(0, 0, 1, 2'd1, 2'd0);
        tick(1);               chk_out("manual_start", 3'b001, 3'b100);
        tick_to(k + 21);       chk_out("manual_mid", 3'b101, 3'b100);
        tick_to(k + 22);       chk_out("manual_last", 3'b101, 3'b100);
        tick_to(k + 23);       chk_out("manual_end", 3'b111, 3'b100);

        // Manual on ch2 while in WAIT: early pulse, period restarts from it.
        tick_to(k + 29);
        cmd(0, 0, 1, 2'd2, 2'd0);
        tick(1); m = cyc;      chk_out("early_pulse", 3'b011, 3'b100);
        tick_to(m + 19);       chk_out("early_pulse_last", 3'b011, 3'b100);
        tick_to(m + 20);       chk_out("early_wait", 3'b111, 3'b100);
        tick_to(m + 49);       chk_out("early_wait_last", 3'b111, 3'b100);
        tick_to(m + 50);       chk_out("retimed_pulse", 3'b011, 3'b100);
        // Manual during PULSE must not stretch it.
        cmd(0, 0, 1, 2'd2, 2'd0);
        tick_to(m + 69);       chk_out("no_extend_last", 3'b011, 3'b100);
        tick_to(m + 70);       chk_out("no_extend_end", 3'b111, 3'b100);

        // pump_off beats pump_on in the same cycle.
        cmd(1, 1, 0, 2'd2, 2'd0);
        tick(1);               chk_out("off_priority", 3'b111, 3'b000);

        // Out-of-range sel is ignored.
        cmd(1, 0, 0, 2'd0, 2'd0); k = cyc;
        tick(1);               chk_out("arm_ch0", 3'b110, 3'b001);
        cmd(1, 0, 0, 2'd3, 2'd0);
        tick(1);               chk_out("bad_sel_on", 3'b110, 3'b001);
        cmd(0, 0, 1, 2'd3, 2'd0);
        tick(1);               chk_out("bad_sel_man", 3'b110, 3'b001);

        // pump_off on the last PULSE cycle: IDLE, not WAIT.
        tick_to(k + 19);
        cmd(0, 1, 0, 2'd0, 2'd0);
        chk_out("terminal_hold", 3'b110, 3'b001);
        tick(1);               chk_out("terminal_off", 3'b111, 3'b000);

        // Async reset in the middle of a pulse.
        cmd(1, 0, 0, 2'd1, 2'd0);
        tick(3);               chk_out("pre_reset", 3'b101, 3'b010);
        #2 rst_n = 1'b0;
        #1                     chk_out("async_reset", 3'b111, 3'b000);
        tick(1);
        rst_n = 1'b1;
        tick(2);               chk_out("post_reset", 3'b111, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pump_scheduler.md
# pump_scheduler

Parametrised N-channel fragrance pump scheduler. It replaces the fixed three-pump controller with a generate-based array of identical channel engines. A single channel is armed for periodic dispensing at a time. Each channel runs a cycle-exact pulse/wait schedule with the period latched at arm time, and the block accepts one-shot manual pulses. It sits between the front-panel command decoder and the active-low pump driver pins.

## Interface
- `NUM_PUMPS`, default 3: number of channels, range 1..8.
- `CLOCK_FREQ`, default 1_000_000: clk cycles per second.
- `ON_SEC`, default 5: pulse length in seconds, ≥1.
- `PERIOD0_SEC`, default 1800: period in seconds for `period_sel`=0.
- `PERIOD1_SEC`, default 3600: period in seconds for `period_sel`=1.
- `PERIOD2_SEC`, default 7200: period in seconds for `period_sel`=2. `period_sel`=3 also maps to PERIOD0.
- `SEL_W`, derived as max(1, clog2(NUM_PUMPS)); not overridden.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `sel`, in, SEL_W: target channel index.
- `period_sel`, in, 2: period choice, sampled only on arm.
- `pump_on`, in, 1: one-cycle strobe that arms channel `sel`.
- `pump_off`, in, 1: one-cycle strobe that disarms all channels.
- `manual_on`, in, 1: one-cycle strobe that requests a one-shot pulse on `sel`.
- `pump_out`, out, NUM_PUMPS: active-low drive; 0 = pump running.
- `armed`, out, NUM_PUMPS: one-hot or zero; marks the channel under periodic schedule.

## Operation
- Each channel has four states: IDLE, PULSE, WAIT, MANUAL.
  - `pump_out[i]`=0 only in PULSE or MANUAL.
  - `armed[i]`=1 in PULSE or WAIT.
- Command priority in a single cycle is `pump_off` > `pump_on` > `manual_on`. Lower-priority strobes in that cycle are dropped.
- `pump_off`: every channel goes to IDLE and its counters clear.
- `pump_on` with `sel` < NUM_PUMPS:
  - The target channel latches its period and enters PULSE, even if it was already armed (restart).
  - Every other channel goes to IDLE, including one in MANUAL.
- `manual_on` with `sel` < NUM_PUMPS, by target-channel state:
  - IDLE: enter MANUAL.
  - WAIT: enter PULSE early; the period restarts from this pulse.
  - PULSE or MANUAL: ignored.
  - Other channels are unaffected.
- A command with `sel` ≥ NUM_PUMPS is ignored entirely; no channel changes.
- Normal transitions:
  - PULSE → WAIT after ON_SEC·CLOCK_FREQ cycles.
  - WAIT → PULSE after W·CLOCK_FREQ cycles, where W = max(P − ON_SEC, 1) and P is the latched period.
  - MANUAL → IDLE after ON_SEC·CLOCK_FREQ cycles.
- Each channel uses a prescaler (width clog2(CLOCK_FREQ)) plus a 32-bit seconds counter. Both clear on every state entry, so there is no shared-tick jitter.
- A `period_sel` change while armed has no effect until the next `pump_on`.

## Timing
- Reset state: all channels IDLE, `pump_out` all ones, `armed` = 0, all counters 0.
- Commands are registered. A strobe sampled at edge k changes state and outputs after edge k+1; this is one cycle of latency.
- PULSE and MANUAL hold `pump_out[i]` low for exactly ON_SEC·CLOCK_FREQ cycles.
- Armed start-to-start spacing is exactly (ON_SEC+W)·CLOCK_FREQ cycles.
- At the terminal cycle of a state, a simultaneous command wins over the natural transition. Example: `pump_off` at the last PULSE cycle gives IDLE, not WAIT.
- Reset asserted mid-pulse forces all outputs high immediately, without waiting for a clock edge.
- Strobes held high for multiple cycles are re-evaluated every cycle:
  - `pump_on` held high restarts the pulse each cycle.
  - `manual_on` held high is ignored after the first accepted cycle.

## Structure
- Package `pump_pkg`:
  - state enum `pump_state_t` {IDLE, PULSE, WAIT, MANUAL};
  - period-select encodings;
  - function `period_lookup(period_sel)` returning seconds.
- Sub-module `pump_channel`, generated NUM_PUMPS times, containing:
  - the state register;
  - the prescaler and seconds counter;
  - the latched period.
- Top level `pump_scheduler`:
  - registers and decodes commands into per-channel arm, stop and manual strobes;
  - concatenates the channel outputs.

## Test plan
Bench uses CLOCK_FREQ=10, ON_SEC=2, PERIOD0/1/2 = 5/1/8, NUM_PUMPS=3.
- Reset check: after reset release, `pump_out`=3'b111 and `armed`=0.
- Arm, with period 5: `pump_on` with sel=1, period_sel=0 at edge k → `pump_out`=3'b101 for cycles k+1..k+20, high for 30 cycles, low again at k+51; `armed`=3'b010.
- Clamp, with period 1: period_sel=1 arm → pulses of 20 cycles every 30 cycles (W clamped to 1 s).
- Re-arm and manual: arm ch0, then `pump_on` on ch2 → ch0 IDLE and ch2 PULSE from the same edge; `manual_on` on ch1 → 20-cycle pulse on ch1 while `armed` stays 3'b100.
- Manual in WAIT and re-timing: `manual_on` on the armed ch2 in WAIT → immediate pulse and next pulse 50 cycles later; `manual_on` during PULSE → no extension.
- Priority, invalid sel, async reset:
  - `pump_off`+`pump_on` in the same cycle → all IDLE;
  - sel=3 → no change;
  - `rst_n` low mid-pulse → `pump_out`=3'b111 with no clock edge.
